// File: rtl/traffic_ctrl_param.sv
// Two-direction intersection controller with a one-second prescaler, a pedestrian
// walk phase, a night flashing-yellow mode and per-direction BCD countdowns.
module traffic_ctrl_param #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int GREEN_S     = 7,
    parameter int YELLOW_S    = 3,
    parameter int ALLRED_S    = 1,
    parameter int WALK_S      = 5,
    parameter int PED_GREEN_S = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       night_mode,
    input  logic       ped_req,
    output logic       xanh_1,
    output logic       vang_1,
    output logic       do_1,
    output logic       xanh_2,
    output logic       vang_2,
    output logic       do_2,
    output logic [3:0] cnt1_tens,
    output logic [3:0] cnt1_ones,
    output logic [3:0] cnt2_tens,
    output logic [3:0] cnt2_ones,
    output logic       ped_walk
);
    // state  | meaning
    // S_G2   | direction 2 green, direction 1 red
    // S_Y2   | direction 2 yellow, direction 1 red
    // S_AR_A | all red (walk phase when walk_q)
    // S_G1   | direction 1 green, direction 2 red
    // S_Y1   | direction 1 yellow, direction 2 red
    // S_AR_B | all red (walk phase when walk_q)
    // S_NIGHT| both yellows flash on blink, everything else dark
    typedef enum logic [2:0] {S_G2, S_Y2, S_AR_A, S_G1, S_Y1, S_AR_B, S_NIGHT} state_t;

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [6:0] G_S   = 7'(GREEN_S);
    localparam logic [6:0] Y_S   = 7'(YELLOW_S);
    localparam logic [6:0] AR_S  = 7'(ALLRED_S);
    localparam logic [6:0] WK_S  = 7'(WALK_S);
    localparam logic [6:0] PG_S  = 7'(PED_GREEN_S);
    localparam logic [6:0] Y_AR  = 7'(YELLOW_S + ALLRED_S);

    state_t        state_q, state_d;
    logic [6:0]    rem_q, rem_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          pend_q, pend_d;
    logic          blink_q, blink_d;
    logic          walk_q, walk_d;
    logic          tick;
    logic [6:0]    disp1, disp2;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [6:0] rest;
        tens = 4'd0;
        rest = v;
        for (int i = 0; i < 9; i++) begin
            if (rest >= 7'd10) begin
                rest = rest - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rest[3:0]};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_G2;
            rem_q   <= G_S;
            pre_q   <= '0;
            pend_q  <= 1'b0;
            blink_q <= 1'b0;
            walk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pre_q   <= pre_d;
            pend_q  <= pend_d;
            blink_q <= blink_d;
            walk_q  <= walk_d;
        end
    end

    always_comb begin
        tick    = (pre_q == PRE_LAST);
        pre_d   = tick ? '0 : pre_q + 1'b1;
        state_d = state_q;
        rem_d   = rem_q;
        blink_d = blink_q;
        walk_d  = walk_q;
        pend_d  = pend_q | ped_req;
        if (tick) begin
            if (night_mode) begin
                state_d = S_NIGHT;
                blink_d = (state_q == S_NIGHT) ? ~blink_q : 1'b0;
                walk_d  = 1'b0;
            end else if (state_q == S_NIGHT || rem_q == 7'd1) begin
                walk_d = 1'b0;
                case (state_q)
                    S_G2:    begin state_d = S_Y2; rem_d = Y_S; end
                    S_Y2:    state_d = S_AR_A;
                    S_AR_A:  begin state_d = S_G1; rem_d = G_S; end
                    S_G1:    begin state_d = S_Y1; rem_d = Y_S; end
                    S_Y1:    state_d = S_AR_B;
                    default: begin state_d = S_G2; rem_d = G_S; end
                endcase
                if (state_q == S_NIGHT) state_d = S_AR_B;
                // Entering either all-red: a pending request turns it into a walk phase.
                if (state_d == S_AR_A || state_d == S_AR_B) begin
                    rem_d  = pend_q ? WK_S : AR_S;
                    walk_d = pend_q;
                    if (pend_q) pend_d = ped_req;
                end
            end else if ((state_q == S_G1 || state_q == S_G2) && pend_q && rem_q > PG_S) begin
                rem_d = PG_S;
            end else begin
                rem_d = rem_q - 7'd1;
            end
        end
    end

    always_comb begin
        {xanh_1, vang_1, do_1, xanh_2, vang_2, do_2} = 6'b001001;
        disp1    = rem_q;
        disp2    = rem_q;
        ped_walk = 1'b0;
        case (state_q)
            S_G2:    begin xanh_2 = 1'b1; do_2 = 1'b0; disp1 = rem_q + Y_AR; end
            S_Y2:    begin vang_2 = 1'b1; do_2 = 1'b0; disp1 = rem_q + AR_S; end
            S_G1:    begin xanh_1 = 1'b1; do_1 = 1'b0; disp2 = rem_q + Y_AR; end
            S_Y1:    begin vang_1 = 1'b1; do_1 = 1'b0; disp2 = rem_q + AR_S; end
            S_NIGHT: begin
                {xanh_1, vang_1, do_1, xanh_2, vang_2, do_2} = {1'b0, blink_q, 1'b0, 1'b0, blink_q, 1'b0};
                disp1 = 7'd0;
                disp2 = 7'd0;
            end
            default: ped_walk = walk_q;
        endcase
        {cnt1_tens, cnt1_ones} = to_bcd(disp1);
        {cnt2_tens, cnt2_ones} = to_bcd(disp2);
    end
endmodule

// File: doc/traffic_ctrl_param.md
# traffic_ctrl_param

Parametrised two-direction intersection controller. It is the successor to the fixed 9/7/3-second controller. An internal prescaler produces a one-second tick from `clk`. On that tick the block sequences green, yellow and all-red phases with configurable durations. It also adds a pedestrian-request/walk phase and a night flashing-yellow mode, and drives two-digit BCD countdowns per direction for the seven-segment decoders.

## Interface
- `CLK_HZ`, 50_000_000: clock cycles per one-second tick (≥2).
- `GREEN_S`, 7: nominal green duration, seconds.
- `YELLOW_S`, 3: yellow duration, seconds.
- `ALLRED_S`, 1: all-red clearance, seconds.
- `WALK_S`, 5: all-red duration when it serves a pedestrian request.
- `PED_GREEN_S`, 2: green remaining after a pedestrian request shortens green.
- Constraints: all durations ≥1; `GREEN_S+YELLOW_S+max(ALLRED_S,WALK_S)` ≤ 99; `PED_GREEN_S` < `GREEN_S`.
- `clk` input 1: single system clock.
- `reset` input 1: asynchronous, active-low reset.
- `night_mode` input 1: level; high requests flashing-yellow mode.
- `ped_req` input 1: pedestrian button, level or pulse ≥1 cycle.
- `xanh_1`, `vang_1`, `do_1` output 1 each: direction-1 green/yellow/red.
- `xanh_2`, `vang_2`, `do_2` output 1 each: direction-2 green/yellow/red.
- `cnt1_tens`, `cnt1_ones` output 4 each: direction-1 countdown, BCD.
- `cnt2_tens`, `cnt2_ones` output 4 each: direction-2 countdown, BCD.
- `ped_walk` output 1: pedestrian walk lamp.

## Operation
- States: G2 (d2 green, d1 red), Y2 (d2 yellow, d1 red), AR_A (all red), G1 (d1 green, d2 red), Y1 (d1 yellow, d2 red), AR_B (all red), NIGHT.
- Normal sequence: G2→Y2→AR_A→G1→Y1→AR_B→G2.
- `rem`: seconds-remaining register.
  - Loaded with the state duration on entry.
  - On each tick: if `rem`==1, transition to the next state; else `rem`−1.
- Exactly one of green/yellow/red is high per direction, except in NIGHT.
- Pedestrian handling:
  - `ped_pending` sets in any cycle `ped_req`=1, including during NIGHT.
  - In G1/G2 on a tick, if `ped_pending` and `rem`>`PED_GREEN_S`, `rem` loads `PED_GREEN_S` instead of decrementing.
  - Entering AR_A/AR_B with `ped_pending`=1: that all-red lasts `WALK_S`, `ped_walk`=1 for its whole duration, and `ped_pending` clears on entry.
  - A request arriving during a walk phase stays pending for the next all-red.
- Night mode:
  - Entry: on any tick with `night_mode`=1, from any state, go to NIGHT.
  - In NIGHT, all red and green lamps are 0. `vang_1`=`vang_2`=`blink`; `blink` toggles each tick and is 0 on entry. Both countdowns read 00 and `ped_walk`=0.
  - Exit: on a tick with `night_mode`=0, go to AR_B with a normal `ALLRED_S` duration (`WALK_S` if pending), then G2.
- Countdown display:
  - Green/yellow direction shows `rem`.
  - Red direction shows `rem` plus the nominal durations of the remaining states before its green: `YELLOW_S`+`ALLRED_S` from G, `ALLRED_S` from Y, 0 from AR.
  - Value is binary-to-BCD converted; the max is 99, so no saturation is needed.

## Timing
- Prescaler counts 0..`CLK_HZ`−1; `tick` is a one-cycle pulse in the cycle the count equals `CLK_HZ`−1, after which it wraps to 0.
- All state, `rem`, `blink` and `ped_pending` updates occur on the tick cycle edge. Lamps, countdowns and `ped_walk` decode combinationally from registers, so they change on that same edge.
- `ped_req` and a tick in the same cycle: the request is latched and the shortening does not apply until the next tick.
- `night_mode` change takes effect at the next tick; `night_mode` is not sampled between ticks.
- Reset values (asserted asynchronously, held while `reset`=0; unchanged if reset is applied mid-phase or mid-walk):
  - state G2, `rem`=`GREEN_S`, prescaler 0, `ped_pending` 0, `blink` 0.
  - `xanh_2`=1, `do_1`=1, other lamps 0.
  - cnt2=`GREEN_S`, cnt1=`GREEN_S+YELLOW_S+ALLRED_S`, `ped_walk`=0.
- First tick occurs `CLK_HZ` cycles after `reset` deasserts.

## Test plan
All scenarios use `CLK_HZ`=4, G=7, Y=3, AR=1, WALK=5, PED_GREEN=2.
- Reset and no inputs: cnt2=07, cnt1=11. Full cycle G2 7s/Y2 3s/AR_A 1s/G1 7s/Y1 3s/AR_B 1s repeats every 88 clocks, and each countdown decrements once per 4 clocks.
- `ped_req` pulse when G2 `rem`=6: next tick `rem`=2, then 1, then Y2 for 3s. AR_A lasts 5s with `ped_walk`=1, and `ped_pending` reads 0 afterward.
- `ped_req` during Y1: Y1 is unchanged. AR_B lasts 5s with walk, then G2 at full 7s.
- `night_mode`=1 mid-G1: at the next tick, all lamps are off except both yellows at 0, then 1, 0... per tick, with countdowns 00. Dropping `night_mode` gives AR_B 1s then G2.
- Reset pulled low mid-Y2, for one cycle not aligned to `clk`: outputs return immediately to reset values. The first tick comes 4 clocks after release.
- `ped_req` while G1 `rem`=2: no shortening, since `rem` is not > 2. AR_B still becomes a walk phase.
